fcmp_unit: RTL

Pipelined floating-point compare execution unit for the FPU. It accepts issued compare ops (feq/flt/fle) with two single-precision operands and a destination tag over a valid/ready handshake. It evaluates them with the existing `feq`/`flt`/`fle` comparator modules and delivers a zero-extended 32-bit boolean result with its tag to integer writeback. It sits between the issue stage and writeback, with two register stages and full throughput.

---
 rtl/fpu_pkg.sv | 18 +
 rtl/feq.sv | 8 +
 rtl/fle.sv | 12 +
 rtl/flt.sv | 19 +
 rtl/fcmp_unit.sv | 96 +++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU op codes and compare-unit payload types
package fpu_pkg;

  localparam logic [1:0] OP_FEQ = 2'b00;
  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FLE = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam int FPU_TAG_W = 5;

  typedef struct packed {
    logic [1:0]           op;
    logic [31:0]          x;
    logic [31:0]          y;
    logic [FPU_TAG_W-1:0] tag;
  } s0_payload_t;

endpackage

// File: rtl/feq.sv
// rtl/feq.sv - single-precision bitwise equality comparator
module feq (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        z
);
  assign z = (a == b);
endmodule

// File: rtl/fle.sv
// rtl/fle.sv - single-precision less-or-equal built as !(b < a)
module fle (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        z
);
  logic b_lt_a;

  flt u_flt (.a(b), .b(a), .z(b_lt_a));

  assign z = !b_lt_a;
endmodule

// File: rtl/flt.sv
// rtl/flt.sv - single-precision less-than on sign/magnitude ordering, no NaN handling
module flt (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        z
);
  logic mag_lt, mag_gt;

  assign mag_lt = a[30:0] < b[30:0];
  assign mag_gt = a[30:0] > b[30:0];

  // Differing signs: the negative operand is smaller, so -0 < +0.
  always_comb begin
    z = 1'b0;
    if (a[31] != b[31]) z = a[31];
    else if (!a[31])    z = mag_lt;
    else                z = mag_gt;
  end
endmodule

// File: rtl/fcmp_unit.sv
// rtl/fcmp_unit.sv - two-stage pipelined feq/flt/fle execution unit with valid/ready handshake
module fcmp_unit
  import fpu_pkg::*;
#(
  parameter int TAG_W = FPU_TAG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal_op,
  output logic [CNT_W-1:0] cmp_count
);

  if (TAG_W != FPU_TAG_W) begin : g_tag_w_check
    $error("fcmp_unit: TAG_W must equal fpu_pkg::FPU_TAG_W");
  end

  s0_payload_t      s0;
  logic             s0_valid;
  logic             s1_valid;
  logic             s1_z;
  logic [TAG_W-1:0] s1_tag;

  logic s1_free, s0_adv, in_fire, out_fire;
  logic z_eq, z_lt, z_le, z_sel;

  assign s1_free  = !s1_valid || out_ready;
  assign s0_adv   = s0_valid && s1_free;
  assign in_ready = !s0_valid || s1_free;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s1_valid && out_ready;

  feq u_feq (.a(s0.x), .b(s0.y), .z(z_eq));
  flt u_flt (.a(s0.x), .b(s0.y), .z(z_lt));
  fle u_fle (.a(s0.x), .b(s0.y), .z(z_le));

  // Illegal ops still flow through with z=0 so writeback order is preserved.
  always_comb begin
    z_sel = 1'b0;
    case (s0.op)
      OP_FEQ:  z_sel = z_eq;
      OP_FLT:  z_sel = z_lt;
      OP_FLE:  z_sel = z_le;
      default: z_sel = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_valid <= 1'b0;
      s0       <= '0;
    end else begin
      s0_valid <= in_fire || (s0_valid && !s1_free);
      if (in_fire) s0 <= '{op: in_op, x: in_x, y: in_y, tag: in_tag};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_z     <= 1'b0;
      s1_tag   <= '0;
    end else if (s0_adv) begin
      s1_valid <= 1'b1;
      s1_z     <= z_sel;
      s1_tag   <= s0.tag;
    end else if (out_fire) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      illegal_op <= 1'b0;
      cmp_count  <= '0;
    end else begin
      if (in_fire && in_op == OP_ILL) illegal_op <= 1'b1;
      if (out_fire && cmp_count != '1) cmp_count <= cmp_count + 1'b1;
    end
  end

  assign out_valid  = s1_valid;
  assign out_result = {31'b0, s1_z};
  assign out_tag    = s1_tag;

endmodule
